// File: rtl/fft_frame_sequencer_if.sv
// Bus bundle between the frame sequencer, the sample FIFO read port and the
// FFT Avalon-ST sink. The master side is the sequencer.
interface fft_frame_sequencer_if #(
  parameter int DW = 32,
  parameter int CW = 10
);
  logic [CW-1:0] fifo_usedw;
  logic [DW-1:0] fifo_q;
  logic          fifo_rdreq;
  logic          sink_ready;
  logic          sink_valid;
  logic          sink_sop;
  logic          sink_eop;
  logic [DW-1:0] sink_real;

  modport master (
    input  fifo_usedw, fifo_q, sink_ready,
    output fifo_rdreq, sink_valid, sink_sop, sink_eop, sink_real
  );

  modport slave (
    output fifo_usedw, fifo_q, sink_ready,
    input  fifo_rdreq, sink_valid, sink_sop, sink_eop, sink_real
  );
endinterface

// File: rtl/fft_frame_sequencer.sv
// Frame sequencer: waits for N samples in the FIFO, then streams them into
// the FFT sink with sop/eop framing. A 2-entry skid buffer absorbs the
// one-cycle FIFO read latency under sink_ready backpressure. Also keeps
// wrap-around counters of frames accepted by and emitted from the FFT.
module fft_frame_sequencer #(
  parameter int N  = 512,
  parameter int DW = 32,
  parameter int CW = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic                   i_cont_en,
  input  logic                   i_source_valid,
  input  logic                   i_source_eop,
  output logic                   o_busy,
  output logic [15:0]            o_in_frames,
  output logic [15:0]            o_out_frames,
  output logic                   o_underflow,
  fft_frame_sequencer_if.master  bus
);

  localparam logic [CW-1:0] N_C    = CW'(N);
  localparam logic [CW-1:0] LAST_C = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_FILL = 2'd1,
    S_STREAM    = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_rd_cnt;
  logic [CW-1:0] r_tx_cnt;
  logic          r_inflight;
  logic [1:0]    r_buf_cnt;
  logic [DW-1:0] r_buf0;
  logic [DW-1:0] r_buf1;
  logic [15:0]   r_in_frames;
  logic [15:0]   r_out_frames;
  logic          r_underflow;

  logic          w_valid;
  logic          w_accept;
  logic          w_eop_accept;
  logic [1:0]    w_occ_after;
  logic          w_rd_want;
  logic          w_rdreq;

  // Occupancy after this cycle's pop, counting the read already in flight;
  // a new read is only allowed if it still leaves room for its data.
  assign w_valid      = (r_buf_cnt != 2'd0);
  assign w_accept     = w_valid & bus.sink_ready;
  assign w_eop_accept = w_accept & (r_tx_cnt == LAST_C);
  assign w_occ_after  = r_buf_cnt - {1'b0, w_accept} + {1'b0, r_inflight};
  assign w_rd_want    = (r_state == S_STREAM) & (r_rd_cnt < N_C) & (w_occ_after < 2'd2);
  assign w_rdreq      = w_rd_want & (bus.fifo_usedw != {CW{1'b0}});

  assign bus.fifo_rdreq = w_rdreq;
  assign bus.sink_valid = w_valid;
  assign bus.sink_real  = r_buf0;
  assign bus.sink_sop   = w_valid & (r_tx_cnt == {CW{1'b0}});
  assign bus.sink_eop   = w_valid & (r_tx_cnt == LAST_C);

  assign o_busy       = (r_state != S_IDLE);
  assign o_in_frames  = r_in_frames;
  assign o_out_frames = r_out_frames;
  assign o_underflow  = r_underflow;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; cont_en is sampled at the eop accept to pick the loop.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start | i_cont_en) w_state_nxt = S_WAIT_FILL;
        else                     w_state_nxt = S_IDLE;
      end
      S_WAIT_FILL: begin
        if (bus.fifo_usedw >= N_C) w_state_nxt = S_STREAM;
        else                       w_state_nxt = S_WAIT_FILL;
      end
      S_STREAM: begin
        if (w_eop_accept) w_state_nxt = i_cont_en ? S_WAIT_FILL : S_IDLE;
        else              w_state_nxt = S_STREAM;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Per-frame read and accept counters, cleared together at the eop accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_cnt   <= {CW{1'b0}};
      r_tx_cnt   <= {CW{1'b0}};
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rdreq;
      if (w_eop_accept) begin
        r_rd_cnt <= {CW{1'b0}};
        r_tx_cnt <= {CW{1'b0}};
      end else begin
        if (w_rdreq)  r_rd_cnt <= r_rd_cnt + {{(CW-1){1'b0}}, 1'b1};
        if (w_accept) r_tx_cnt <= r_tx_cnt + {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

  // Two-entry buffer: r_buf0 is the head; pushes come from last cycle's read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf_cnt <= 2'd0;
      r_buf0    <= {DW{1'b0}};
      r_buf1    <= {DW{1'b0}};
    end else begin
      case ({r_inflight, w_accept})
        2'b10: begin
          if (r_buf_cnt == 2'd0) r_buf0 <= bus.fifo_q;
          else                   r_buf1 <= bus.fifo_q;
          r_buf_cnt <= r_buf_cnt + 2'd1;
        end
        2'b01: begin
          r_buf0    <= r_buf1;
          r_buf_cnt <= r_buf_cnt - 2'd1;
        end
        2'b11: begin
          if (r_buf_cnt == 2'd1) begin
            r_buf0 <= bus.fifo_q;
          end else begin
            r_buf0 <= r_buf1;
            r_buf1 <= bus.fifo_q;
          end
        end
        default: r_buf_cnt <= r_buf_cnt;
      endcase
    end
  end

  // Frame statistics and the sticky underflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_frames  <= 16'd0;
      r_out_frames <= 16'd0;
      r_underflow  <= 1'b0;
    end else begin
      if (w_eop_accept) r_in_frames <= r_in_frames + 16'd1;
      if (i_source_valid & i_source_eop) r_out_frames <= r_out_frames + 16'd1;
      if (w_rd_want & (bus.fifo_usedw == {CW{1'b0}})) r_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer: a ramp-data FIFO model feeds the
// design; every accepted sample is checked against the value read for it.
module tb_fft_frame_sequencer;
  localparam int N  = 512;
  localparam int DW = 32;
  localparam int CW = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, cont_en, source_valid, source_eop;
  logic        busy, underflow;
  logic [15:0] in_frames, out_frames;

  fft_frame_sequencer_if #(.DW(DW), .CW(CW)) bus ();

  fft_frame_sequencer #(.N(N), .DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .i_start(start), .i_cont_en(cont_en),
    .i_source_valid(source_valid), .i_source_eop(source_eop),
    .o_busy(busy), .o_in_frames(in_frames), .o_out_frames(out_frames),
    .o_underflow(underflow), .bus(bus)
  );

  always #5 clk = ~clk;

  // FIFO model: sample value = running read index, level = filled - read.
  int fill_total = 0;
  int rd_total   = 0;
  int avail;
  bit zero_usedw = 1'b0;
  assign avail = fill_total - rd_total;

  always_comb begin
    if (zero_usedw)      bus.fifo_usedw = 10'd0;
    else if (avail >= N) bus.fifo_usedw = 10'(N);
    else                 bus.fifo_usedw = 10'(avail);
  end

  always_ff @(posedge clk) begin
    if (bus.fifo_rdreq === 1'b1) begin
      bus.fifo_q <= 32'(rd_total);
      rd_total   <= rd_total + 1;
    end
  end

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  int acc_total = 0, acc_in_frame = 0, sops = 0, eops = 0, rdreqs = 0;
  int valid_run = 0, max_run = 0, max_out = 0;
  logic last_rdreq = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: observe at the falling edge, return just after the rising edge.
  task automatic tick();
    logic [31:0] e;
    @(negedge clk);
    if (bus.sink_valid === 1'b1) begin
      valid_run++;
      if (valid_run > max_run) max_run = valid_run;
    end else begin
      valid_run = 0;
    end
    if (bus.sink_valid === 1'b1 && bus.sink_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("pending_reads", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("sink_real", bus.sink_real, e);
      end
      chk("sink_sop", 32'(bus.sink_sop), 32'(acc_in_frame == 0));
      chk("sink_eop", 32'(bus.sink_eop), 32'(acc_in_frame == N - 1));
      if (bus.sink_sop === 1'b1) sops++;
      if (bus.sink_eop === 1'b1) eops++;
      acc_total++;
      acc_in_frame = (acc_in_frame == N - 1) ? 0 : acc_in_frame + 1;
    end
    last_rdreq = bus.fifo_rdreq;
    if (bus.fifo_rdreq === 1'b1) begin
      chk("rdreq_nonempty", 32'(bus.fifo_usedw != 10'd0), 32'd1);
      exp_q.push_back(32'(rd_total));
      rdreqs++;
      if (exp_q.size() > max_out) max_out = exp_q.size();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_idle(input int limit);
    for (int i = 0; i < limit; i++) begin
      tick();
      if (busy === 1'b0) break;
    end
    chk("idle_within_budget", 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    acc_in_frame = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(bus.sink_valid), 32'd0);
    chk({tag, "_sop"}, 32'(bus.sink_sop), 32'd0);
    chk({tag, "_eop"}, 32'(bus.sink_eop), 32'd0);
    chk({tag, "_real"}, bus.sink_real, 32'd0);
    chk({tag, "_rdreq"}, 32'(bus.fifo_rdreq), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_in_frames"}, 32'(in_frames), 32'd0);
    chk({tag, "_out_frames"}, 32'(out_frames), 32'd0);
    chk({tag, "_underflow"}, 32'(underflow), 32'd0);
  endtask

  int a0, s0, e0, r0;
  logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    rst = 1'b1; start = 1'b0; cont_en = 1'b0;
    source_valid = 1'b0; source_eop = 1'b0; bus.sink_ready = 1'b1;
    tick();
    do_reset();
    check_reset_outputs("reset");

    // 1: single full frame with sink_ready held high
    fill_total += N;
    a0 = acc_total; s0 = sops; e0 = eops; max_run = 0;
    start = 1'b1; tick(); start = 1'b0;
    run_until_idle(2000);
    chk("t1_accepts", 32'(acc_total - a0), 32'(N));
    chk("t1_sops", 32'(sops - s0), 32'd1);
    chk("t1_eops", 32'(eops - e0), 32'd1);
    chk("t1_valid_run", 32'(max_run), 32'(N));
    chk("t1_in_frames", 32'(in_frames), 32'd1);

    // 2: partial fill holds WAIT_FILL, completion releases STREAM next cycle
    fill_total += 300;
    r0 = rdreqs;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("t2_waiting_busy", 32'(busy), 32'd1);
    chk("t2_no_rdreq", 32'(rdreqs - r0), 32'd0);
    fill_total += N - 300;
    tick();
    chk("t2_rdreq_not_yet", 32'(last_rdreq), 32'd0);
    tick();
    chk("t2_first_rdreq", 32'(last_rdreq), 32'd1);
    run_until_idle(2000);
    chk("t2_in_frames", 32'(in_frames), 32'd2);

    // 3: backpressure pattern with random flips
    fill_total += N;
    a0 = acc_total; e0 = eops; max_out = 0;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      bus.sink_ready = pat[i % 4] ^ ($urandom_range(0, 7) == 0);
      tick();
      if (busy === 1'b0) break;
    end
    bus.sink_ready = 1'b1;
    chk("t3_idle", 32'(busy), 32'd0);
    chk("t3_accepts", 32'(acc_total - a0), 32'(N));
    chk("t3_eops", 32'(eops - e0), 32'd1);
    chk("t3_max_outstanding_le2", 32'(max_out <= 2), 32'd1);
    chk("t3_in_frames", 32'(in_frames), 32'd3);

    // 4: continuous mode, three frames, cont_en dropped inside the third
    fill_total += 3 * N;
    a0 = acc_total; s0 = sops; e0 = eops;
    cont_en = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      tick();
      if (eops - e0 == 2 && acc_in_frame >= 10) cont_en = 1'b0;
      if (busy === 1'b0) break;
    end
    chk("t4_idle", 32'(busy), 32'd0);
    chk("t4_accepts", 32'(acc_total - a0), 32'(3 * N));
    chk("t4_sops", 32'(sops - s0), 32'd3);
    chk("t4_eops", 32'(eops - e0), 32'd3);
    chk("t4_in_frames", 32'(in_frames), 32'd6);
    for (int i = 0; i < 5; i++) tick();
    chk("t4_stays_idle", 32'(busy), 32'd0);

    // 5: reset at sample 100, then a clean restart
    fill_total += N;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (acc_in_frame == 100) break;
      tick();
    end
    chk("t5_reached_sample_100", 32'(acc_in_frame), 32'd100);
    do_reset();
    check_reset_outputs("t5_midframe_rst");
    fill_total += N;
    a0 = acc_total; s0 = sops; e0 = eops;
    start = 1'b1; tick(); start = 1'b0;
    run_until_idle(2000);
    chk("t5_accepts", 32'(acc_total - a0), 32'(N));
    chk("t5_sops", 32'(sops - s0), 32'd1);
    chk("t5_eops", 32'(eops - e0), 32'd1);
    chk("t5_in_frames", 32'(in_frames), 32'd1);

    // 6: empty FIFO during STREAM, then FFT output frame counting
    fill_total += N;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (acc_in_frame == 5) break;
      tick();
    end
    zero_usedw = 1'b1;
    tick();
    chk("t6_rdreq_suppressed", 32'(last_rdreq), 32'd0);
    tick();
    chk("t6_underflow_set", 32'(underflow), 32'd1);
    chk("t6_rdreq_still_off", 32'(last_rdreq), 32'd0);
    zero_usedw = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("t6_underflow_sticky", 32'(underflow), 32'd1);
    for (int i = 0; i < 4; i++) begin
      source_valid = 1'b1; source_eop = 1'b1; tick();
      source_valid = 1'b0; source_eop = 1'b0; tick();
    end
    source_valid = 1'b1; tick(); source_valid = 1'b0;
    source_eop = 1'b1; tick(); source_eop = 1'b0;
    tick();
    chk("t6_out_frames", 32'(out_frames), 32'd4);
    do_reset();
    chk("t6_underflow_cleared", 32'(underflow), 32'd0);
    chk("t6_out_frames_cleared", 32'(out_frames), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
